// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD ALU blocks: datapath width, lane modes and lane helpers.
package simd_pkg;

    localparam int SIMD_WIDTH = 256;
    localparam int CNT_W      = 9;

    typedef enum logic [2:0] {
        MODE_8   = 3'd0,
        MODE_16  = 3'd1,
        MODE_32  = 3'd2,
        MODE_64  = 3'd3,
        MODE_128 = 3'd4,
        MODE_256 = 3'd5
    } mode_e;

    // Encodings 5..7 all select a single full-width lane.
    function automatic int lane_width(input logic [2:0] mode);
        return (mode > 3'd4) ? SIMD_WIDTH : (8 << mode);
    endfunction

    function automatic logic [SIMD_WIDTH-1:0] lane_msb_mask(input logic [2:0] mode);
        logic [SIMD_WIDTH-1:0] mask;
        int lw;
        lw   = lane_width(mode);
        mask = '0;
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            mask[i] = (((i + 1) & (lw - 1)) == 0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/simd_div_step.sv
// One restoring-division step over all lanes at once; carries are cut at every lane boundary.
module simd_div_step
    import simd_pkg::*;
(
    input  logic [SIMD_WIDTH-1:0] rem,
    input  logic [SIMD_WIDTH-1:0] dq,
    input  logic [SIMD_WIDTH-1:0] divisor,
    input  logic [2:0]            mode,
    output logic [SIMD_WIDTH-1:0] rem_next,
    output logic [SIMD_WIDTH-1:0] dq_next
);

    localparam int NBYTES = SIMD_WIDTH / 8;

    int                    lw;
    logic [SIMD_WIDTH-1:0] msb_mask;
    logic [SIMD_WIDTH-1:0] rem_sh;
    logic [SIMD_WIDTH-1:0] dq_sh;
    logic [SIMD_WIDTH-1:0] diff;
    logic [NBYTES-1:0]     ge;
    logic [NBYTES-1:0]     take;
    logic [8:0]            sum;
    logic                  cin;
    logic                  sel;

    assign lw       = lane_width(mode);
    assign msb_mask = lane_msb_mask(mode);

    // dq holds the unconsumed dividend in its top bits and accumulated quotient bits at the bottom.
    always_comb begin
        rem_sh = '0;
        dq_sh  = '0;
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            if ((i & (lw - 1)) == 0) begin
                rem_sh[i] = dq[8'(i + lw - 1)];
                dq_sh[i]  = 1'b0;
            end else begin
                rem_sh[i] = rem[8'(i - 1)];
                dq_sh[i]  = dq[8'(i - 1)];
            end
        end
    end

    // Byte-sliced subtract; the bit shifted out of a lane's remainder MSB forces a subtract.
    always_comb begin
        diff = '0;
        ge   = '0;
        sum  = '0;
        cin  = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
            sum = {1'b0, rem_sh[b*8 +: 8]} + {1'b0, ~divisor[b*8 +: 8]} + {8'd0, cin};
            diff[b*8 +: 8] = sum[7:0];
            if (msb_mask[b*8 + 7]) begin
                ge[b] = sum[8] | rem[b*8 + 7];
                cin   = 1'b1;
            end else begin
                ge[b] = 1'b0;
                cin   = sum[8];
            end
        end
    end

    // Broadcast each lane's decision from its top byte down to all of its bytes.
    always_comb begin
        take = '0;
        sel  = 1'b0;
        for (int b = NBYTES - 1; b >= 0; b--) begin
            if (msb_mask[b*8 + 7]) begin
                sel = ge[b];
            end
            take[b] = sel;
        end
    end

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign rem_next[gi*8 +: 8] = take[gi] ? diff[gi*8 +: 8] : rem_sh[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        dq_next = dq_sh;
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            if ((i & (lw - 1)) == 0) begin
                dq_next[i] = take[i / 8];
            end
        end
    end

endmodule

// File: rtl/simd_divider.sv
// Multi-cycle unsigned SIMD divider: one quotient bit per clock in every lane, valid/ready handshake.
module simd_divider
    import simd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] A,
    input  logic [SIMD_WIDTH-1:0] B,
    input  logic [2:0]            data_mode,
    input  logic                  imm_flag,
    input  logic [7:0]            imm_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] quotient,
    output logic [SIMD_WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                state_reg;
    logic [CNT_W-1:0]      counter_reg;
    logic [SIMD_WIDTH-1:0] rem_reg;
    logic [SIMD_WIDTH-1:0] dq_reg;
    logic [SIMD_WIDTH-1:0] div_reg;
    logic [2:0]            mode_reg;
    logic [SIMD_WIDTH-1:0] rem_next;
    logic [SIMD_WIDTH-1:0] dq_next;
    logic [SIMD_WIDTH-1:0] imm_bcast;
    int                    in_lw;

    assign in_lw = lane_width(data_mode);

    // Immediate is zero-extended into the low byte of every lane.
    generate
        for (genvar gi = 0; gi < SIMD_WIDTH / 8; gi++) begin : g_imm
            assign imm_bcast[gi*8 +: 8] = (((gi * 8) & (in_lw - 1)) == 0) ? imm_reg : 8'd0;
        end
    endgenerate

    simd_div_step u_step (
        .rem      (rem_reg),
        .dq       (dq_reg),
        .divisor  (div_reg),
        .mode     (mode_reg),
        .rem_next (rem_next),
        .dq_next  (dq_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            rem_reg     <= '0;
            dq_reg      <= '0;
            div_reg     <= '0;
            mode_reg    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        dq_reg      <= A;
                        div_reg     <= imm_flag ? imm_bcast : B;
                        mode_reg    <= data_mode;
                        rem_reg     <= '0;
                        counter_reg <= CNT_W'(in_lw);
                        in_ready    <= 1'b0;
                        state_reg   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // W steps, then one publish cycle: out_valid lands W+1 clocks after accept.
                    if (counter_reg != '0) begin
                        rem_reg     <= rem_next;
                        dq_reg      <= dq_next;
                        counter_reg <= counter_reg - CNT_W'(1);
                    end else begin
                        quotient  <= dq_reg;
                        remainder <= rem_reg;
                        out_valid <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
